// File: rtl/fifo_16b_if.sv
// Handshake bundle between a producer/consumer pair and fifo_16b.
// The FIFO takes the slave view; the environment driving it takes the master view.
interface fifo_16b_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             flush;
  logic [WIDTH-1:0] inData;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] outData;
  logic             outValid;
  logic             outReady;
  logic [CNT_W-1:0] count;

  modport master (
    output flush,
    output inData,
    output inValid,
    input  inReady,
    input  outData,
    input  outValid,
    output outReady,
    input  count
  );

  modport slave (
    input  flush,
    input  inData,
    input  inValid,
    output inReady,
    output outData,
    output outValid,
    input  outReady,
    output count
  );
endinterface

// File: rtl/fifo_16b.sv
// Show-ahead synchronous FIFO with valid/ready on both sides.
// The head word is presented combinationally from storage so that a push
// becomes visible one edge later and a pop exposes the next word right away.
// Ready/valid are decoded from the registered occupancy only.
module fifo_16b #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  fifo_16b_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Status flags come from registered state only; no path from inValid/outReady.
  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    push  = bus.inValid & ~full;
    pop   = bus.outReady & ~empty;
  end

  // Next-state for pointers and occupancy; flush overrides any transfer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; reset clears them without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are deliberately left unreset, and a flushed push is dropped.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) mem[wr_ptr_q] <= bus.inData;
  end

  // Outputs: head word shown only while the queue holds something.
  always_comb begin
    bus.inReady  = ~full;
    bus.outValid = ~empty;
    bus.count    = count_q;
    bus.outData  = empty ? '0 : mem[rd_ptr_q];
  end
endmodule

// File: tb/tb_fifo_16b.sv
// Directed testbench for fifo_16b: reset, fill/drain, concurrent push/pop,
// streaming across pointer wraps, flush priority and asynchronous reset.
module tb_fifo_16b;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  fifo_16b_if #(.WIDTH(16), .CNT_W(4)) bus ();

  fifo_16b #(.WIDTH(16), .DEPTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush    = 1'b0;
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    bus.inData   = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #2;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady: got %b want 1", bus.inReady); end
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid: got %b want 0", bus.outValid); end
    checks++; if (bus.outData !== 16'h0000) begin errors++; $display("FAIL reset_outData: got %h want 0000", bus.outData); end
    tick();
    rst = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) begin
      bus.inValid = 1'b1;
      bus.inData  = 16'h1111 * 16'(i + 1);
      tick();
      checks++; if (bus.count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, i + 1); end
    end
    checks++; if (bus.inReady !== 1'b0) begin errors++; $display("FAIL full_inReady: got %b want 0", bus.inReady); end
    checks++; if (bus.outData !== 16'h1111) begin errors++; $display("FAIL full_head: got %h want 1111", bus.outData); end
    // 9th push held while full
    bus.inData = 16'h9999;
    tick();
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL held_push_count: got %0d want 8", bus.count); end
    // Pop while full with inValid still high: no same-cycle push may occur
    bus.outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = 16'h1111 * 16'(i + 1);
      checks++; if (bus.outData !== exp || bus.outValid !== 1'b1) begin errors++; $display("FAIL drain[%0d]: got %h/%b want %h/1", i, bus.outData, bus.outValid, exp); end
      tick();
      bus.inValid = 1'b0;
      $display("pop %h", exp);
    end
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid: got %b want 0", bus.outValid); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL drain_empty_count: got %0d want 0", bus.count); end
    idle_inputs();
    $display("test_fill_drain done");
  endtask

  task automatic test_push_pop_same();
    for (int i = 0; i < 3; i++) begin
      bus.inValid = 1'b1;
      bus.inData  = 16'h3001 + 16'(i);
      tick();
    end
    bus.outReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.inData = 16'h3004 + 16'(k);
      checks++; if (bus.outData !== 16'h3001 + 16'(k)) begin errors++; $display("FAIL pp_head[%0d]: got %h want %h", k, bus.outData, 16'h3001 + 16'(k)); end
      tick();
      checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL pp_count[%0d]: got %0d want 3", k, bus.count); end
    end
    bus.inValid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checks++; if (bus.outData !== 16'h3006 + 16'(j)) begin errors++; $display("FAIL pp_drain[%0d]: got %h want %h", j, bus.outData, 16'h3006 + 16'(j)); end
      tick();
    end
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL pp_empty: got %b want 0", bus.outValid); end
    idle_inputs();
    $display("test_push_pop_same done");
  endtask

  task automatic test_stream();
    int tx;
    int rx;
    int cyc;
    bit bad;
    tx = 0; rx = 0; cyc = 0; bad = 1'b0;
    while (rx < 20 && cyc < 300) begin
      bus.inValid  = (tx < 20) && (cyc % 4 != 3);
      bus.inData   = 16'(tx);
      bus.outReady = (cyc % 3 != 0);
      #1;
      if (bus.outValid && bus.outReady) begin
        if (bus.outData !== 16'(rx)) begin
          bad = 1'b1;
          $display("FAIL stream_word[%0d]: got %h want %h", rx, bus.outData, 16'(rx));
        end
        rx++;
      end
      if (bus.inValid && bus.inReady) tx++;
      tick();
      cyc++;
    end
    checks++; if (bad) errors++;
    checks++; if (rx !== 20) begin errors++; $display("FAIL stream_count: got %0d want 20", rx); end
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL stream_leftover: got %b want 0", bus.outValid); end
    idle_inputs();
    $display("test_stream done rx=%0d", rx);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      bus.inValid = 1'b1;
      bus.inData  = 16'h5001 + 16'(i);
      tick();
    end
    checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL flush_pre_count: got %0d want 5", bus.count); end
    bus.flush  = 1'b1;
    bus.inData = 16'hABCD;
    tick();
    idle_inputs();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", bus.count); end
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.outValid); end
    bus.outReady = 1'b1;
    tick(); tick(); tick();
    checks++; if (bus.outValid !== 1'b0 || bus.outData === 16'hABCD) begin errors++; $display("FAIL flush_dropped: got %h/%b want 0000/0", bus.outData, bus.outValid); end
    idle_inputs();
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      bus.inValid = 1'b1;
      bus.inData  = 16'h6001 + 16'(i);
      tick();
    end
    bus.inValid = 1'b0;
    checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL ar_pre_count: got %0d want 4", bus.count); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL ar_count: got %0d want 0", bus.count); end
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", bus.outValid); end
    tick();
    rst = 1'b1;
    bus.inValid = 1'b1;
    bus.inData  = 16'h5A5A;
    tick();
    bus.inValid = 1'b0;
    checks++; if (bus.outValid !== 1'b1 || bus.outData !== 16'h5A5A) begin errors++; $display("FAIL ar_next_word: got %h/%b want 5a5a/1", bus.outData, bus.outValid); end
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL ar_next_count: got %0d want 1", bus.count); end
    bus.outReady = 1'b1;
    tick();
    checks++; if (bus.outValid !== 1'b0) begin errors++; $display("FAIL ar_final_empty: got %b want 0", bus.outValid); end
    idle_inputs();
    $display("test_async_reset done");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fill_drain();
    test_push_pop_same();
    test_stream();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
